// File: rtl/sine_sample_gen.sv
// -----------------------------------------------------------------------------
// sine_sample_gen
//
// Three-stage sine sample pipeline fed by the quarter-wave phase controller.
// The quarter-period address is folded using the mirror flag, looked up in a
// 64-entry quarter-sine table, then scaled by a gain and signed. The result is
// one signed sample per accepted address.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset (overrides en)
//   en         in   pipeline advance; low freezes every register
//   in_valid   in   adr/phasepose/signbit/gain are meaningful this cycle
//   adr        in   quarter-period address [ADR_W]
//   phasepose  in   1 = descending quarter (address is mirrored)
//   signbit    in   1 = negative half-period
//   gain       in   unsigned amplitude scale [GAIN_W]
//   sample     out  signed two's-complement sample [DATA_W]
//   out_valid  out  sample carries a valid (non-bubble) result
//   zero_cross out  sign of this valid sample differs from the previous one
//
// The quarter-sine table holds round(127 * sin((2i+1)*pi/256)) for i = 0..63,
// i.e. the values for the default ADR_W = 6 and DATA_W = 8.
// -----------------------------------------------------------------------------
module sine_sample_gen #(
    parameter int ADR_W  = 6,
    parameter int DATA_W = 8,
    parameter int GAIN_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [ADR_W-1:0]         adr,
    input  logic                     phasepose,
    input  logic                     signbit,
    input  logic [GAIN_W-1:0]        gain,
    output logic signed [DATA_W-1:0] sample,
    output logic                     out_valid,
    output logic                     zero_cross
);

    localparam int MAG_W  = DATA_W - 1;       // unsigned magnitude width
    localparam int PROD_W = MAG_W + GAIN_W;   // full-width product

    // Quarter-sine table, half-step offset so mirrored quarters are symmetric.
    // NOTE: a constant ROM needs no reset; only the pipeline state is cleared.
    localparam logic [MAG_W-1:0] QTAB [2**ADR_W] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    // Stage 1: folded address and side-band
    logic [ADR_W-1:0]  s1_fadr;
    logic              s1_sign;
    logic [GAIN_W-1:0] s1_gain;
    logic              s1_valid;

    // Stage 2: table magnitude and side-band
    logic [MAG_W-1:0]  s2_q;
    logic              s2_sign;
    logic [GAIN_W-1:0] s2_gain;
    logic              s2_valid;

    // Stage 3 bookkeeping: sign of the last valid sample
    logic              prev_neg;

    // Stage 3 combinational datapath
    logic [PROD_W-1:0]        prod;
    logic [MAG_W-1:0]         mag;
    logic signed [DATA_W-1:0] smp_next;
    logic                     neg_next;

    // NOTE: every always_comb output gets a default first so no latch can form.
    always_comb begin
        prod     = '0;
        mag      = '0;
        smp_next = '0;
        neg_next = 1'b0;

        prod = {{GAIN_W{1'b0}}, s2_q} * {{MAG_W{1'b0}}, s2_gain};
        // Full-scale gain passes the table value through untouched, so the
        // peak reaches AMP_MAX rather than AMP_MAX*255/256.
        mag  = (&s2_gain) ? s2_q : prod[PROD_W-1:GAIN_W];

        smp_next = s2_sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        // A zero-valued sample counts as positive even on the negative half.
        neg_next = s2_sign && (mag != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_fadr    <= '0;
            s1_sign    <= 1'b0;
            s1_gain    <= '0;
            s1_valid   <= 1'b0;
            s2_q       <= '0;
            s2_sign    <= 1'b0;
            s2_gain    <= '0;
            s2_valid   <= 1'b0;
            sample     <= '0;
            out_valid  <= 1'b0;
            zero_cross <= 1'b0;
            prev_neg   <= 1'b0;
        end else if (en) begin
            // Stage 1: mirror the address in descending quarters
            s1_fadr  <= phasepose ? ~adr : adr;
            s1_sign  <= signbit;
            s1_gain  <= gain;
            s1_valid <= in_valid;

            // Stage 2: table read
            s2_q     <= QTAB[s1_fadr];
            s2_sign  <= s1_sign;
            s2_gain  <= s1_gain;
            s2_valid <= s1_valid;

            // Stage 3: scale, sign, zero-cross tracking. Bubbles still update
            // sample but never touch the stored sign or raise zero_cross.
            sample     <= smp_next;
            out_valid  <= s2_valid;
            zero_cross <= s2_valid && (neg_next != prev_neg);
            if (s2_valid) begin
                prev_neg <= neg_next;
            end
        end
    end

endmodule
